keypad_scan_fifo: RTL and testbench
===================================

// Module: keypad_scan_fifo
// PURPOSE
//   Parametrised matrix-keypad scanner: drives one-hot columns, samples synchronised rows, debounces one key
//   at a time, and queues press/release events in a FIFO. A single-clock valid/ready port feeds the SPI/CPU side.
//   Generalises the fixed 4x4 scanner: any matrix size, programmable scan rate and debounce, release events,
//   buffering with overflow flag. Replaces clkdiv/keypad/synchronizer chain in the top level.
// PARAMETERS
//   NROWS          4     number of row inputs
//   NCOLS          4     number of column outputs
//   SCAN_DIV       16384 clk cycles per scan tick (>=2)
//   DEBOUNCE       4     consecutive ticks a level must hold before an event (>=1)
//   DEPTH          8     FIFO entries (power of 2, >=2)
//   REPORT_RELEASE 1     1: push release events; 0: press events only
//   CODE_W = $clog2(NROWS*NCOLS), derived localparam
// PORTS
//   clk        in   1          system clock
//   reset_n    in   1          synchronous reset, active low
//   rows       in   NROWS      raw row lines, active high, asynchronous
//   cols       out  NCOLS      one-hot column drive, active high
//   ev_valid   out  1          FIFO not empty
//   ev_ready   in   1          consumer accepts head event this cycle
//   ev_data    out  CODE_W+1   {release(1=release,0=press), code}; code = row*NCOLS + col
//   ev_count   out  $clog2(DEPTH)+1  events currently queued
//   key_down   out  1          debounced key held (state HELD or REL_DB)
//   key_code   out  CODE_W     code of held key; valid while key_down
//   overflow   out  1          sticky: an event was dropped because FIFO full
//   clr_ovf    in   1          clears overflow (wins over a same-cycle set)
// BEHAVIOUR
//   Reset (reset_n=0 at posedge clk): cols=1 (col 0), state SCAN, div/debounce counters 0, FIFO empty,
//     ev_valid=0, ev_count=0, key_down=0, key_code=0, overflow=0. Mid-operation reset discards queue.
//   Rows pass a 2-FF synchroniser (rows_s); all decisions use rows_s only.
//   Tick: div counter 0..SCAN_DIV-1; tick=1 for one clk when counter==SCAN_DIV-1, then wraps to 0.
//   FSM advances only on tick cycles; col index wraps NCOLS-1 -> 0. hit = rows_s[lrow] for latched row lrow.
//   SCAN:   rows_s==0 -> advance column. Else latch col, lrow = lowest-index high row, db=1;
//           DEBOUNCE==1 -> push press, go HELD; else go PRESS_DB. Column frozen outside SCAN.
//   PRESS_DB: hit -> db++; on db reaching DEBOUNCE push press, go HELD. !hit -> go SCAN, advance col, no event.
//   HELD:   !hit -> db=1, go REL_DB (DEBOUNCE==1: push release if enabled, go SCAN, advance col). hit -> stay.
//   REL_DB: !hit -> db++; on db reaching DEBOUNCE push release (if REPORT_RELEASE), go SCAN, advance col.
//           hit -> go HELD, no event.
//   Other rows in the frozen column and other keys are ignored while a key is latched (single-key scanner).
//   FIFO: push written at tick edge; ev_valid rises the next clk. ev_data = head entry (registered RAM/array).
//   Pop when ev_valid & ev_ready. Push accepted if !full, or full with same-cycle pop (count unchanged).
//   Push when full without pop: event dropped, overflow<=1. Pop and push on empty FIFO: pop ignored, push kept.
//   Pointers are log2(DEPTH) bits, wrap naturally; ev_count = entries, 0..DEPTH.
//   key_down/key_code registered, update on the same edge as the FSM transition.
// TESTING  (NROWS=4 NCOLS=4 SCAN_DIV=4 DEBOUNCE=3 DEPTH=4 REPORT_RELEASE=1)
//   Reset: hold reset_n=0 3 clks -> cols=4'b0001, ev_valid=0, overflow=0; after release cols rotate every 4 clks,
//     0001->0010->0100->1000->0001.
//   Press row2/col1, hold 40 clks, release 40 clks, ev_ready=1 -> events 5'b0_1001 then 5'b1_1001
//     (code 9); key_down high between them; cols frozen at 4'b0010 while latched.
//   Bounce: row high for 1 tick then low (<DEBOUNCE) -> no event, scanning resumes, ev_count stays 0.
//   Two rows (0,3) high on col0 -> single press code 0; row0 drops while row3 held -> release code 0 only.
//   ev_ready=0, 5 press/release pairs -> ev_count=4, overflow=1 on 5th push; clr_ovf pulse -> overflow=0;
//     drain -> first 4 events in order.
//   Full FIFO with ev_ready=1 on push tick -> push accepted, count stays 4, overflow stays 0.

Source files
------------

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: one-hot column drive, synchronised row sampling, single-key
// debounce FSM and a press/release event FIFO with a valid/ready consumer port.
module keypad_scan_fifo #(
    parameter int NROWS          = 4,
    parameter int NCOLS          = 4,
    parameter int SCAN_DIV       = 16384,
    parameter int DEBOUNCE       = 4,
    parameter int DEPTH          = 8,
    parameter int REPORT_RELEASE = 1,
    localparam int CODE_W        = $clog2(NROWS * NCOLS),
    localparam int CNT_W         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NROWS-1:0]  rows,
    output logic [NCOLS-1:0]  cols,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CODE_W:0]   ev_data,
    output logic [CNT_W-1:0]  ev_count,
    output logic              key_down,
    output logic [CODE_W-1:0] key_code,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int ROW_W = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int COL_W = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    state_t             state_reg, state_next;
    logic [NROWS-1:0]   rows_meta_reg, rows_s_reg;
    logic [DIV_W-1:0]   div_reg;
    logic               tick;
    logic [COL_W-1:0]   col_reg, col_next, col_adv;
    logic [ROW_W-1:0]   lrow_reg, lrow_next, first_row, code_row;
    logic [DB_W-1:0]    db_reg, db_next, db_inc;
    logic               hit, push, push_rel;
    logic [CODE_W-1:0]  ev_code;
    logic               key_down_reg;
    logic [CODE_W-1:0]  key_code_reg;

    logic [CODE_W:0]    mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CODE_W:0]    data_reg, push_data;
    logic               ovf_reg, full, pop, wr_en, drop, bypass;

    assign tick    = (div_reg == DIV_W'(SCAN_DIV - 1));
    assign col_adv = (col_reg == COL_W'(NCOLS - 1)) ? '0 : col_reg + 1'b1;
    assign db_inc  = db_reg + 1'b1;
    assign hit     = rows_s_reg[lrow_reg];

    for (genvar gi = 0; gi < NCOLS; gi++) begin : g_cols
        assign cols[gi] = (col_reg == COL_W'(gi));
    end

    // Lowest-index active row wins when several rows are high in the scanned column.
    always_comb begin
        first_row = '0;
        for (int i = NROWS - 1; i >= 0; i--) begin
            if (rows_s_reg[i]) first_row = ROW_W'(i);
        end
    end

    assign code_row = (state_reg == SCAN) ? first_row : lrow_reg;
    assign ev_code  = CODE_W'(int'(code_row) * NCOLS + int'(col_reg));

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        lrow_next  = lrow_reg;
        db_next    = db_reg;
        push       = 1'b0;
        push_rel   = 1'b0;
        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (rows_s_reg == '0) begin
                        col_next = col_adv;
                    end else begin
                        lrow_next = first_row;
                        db_next   = DB_W'(1);
                        if (DEBOUNCE == 1) begin
                            push       = 1'b1;
                            state_next = HELD;
                        end else begin
                            state_next = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (hit) begin
                        db_next = db_inc;
                        if (db_inc == DB_W'(DEBOUNCE)) begin
                            push       = 1'b1;
                            state_next = HELD;
                        end
                    end else begin
                        state_next = SCAN;
                        col_next   = col_adv;
                    end
                end
                HELD: begin
                    if (!hit) begin
                        db_next = DB_W'(1);
                        if (DEBOUNCE == 1) begin
                            push       = (REPORT_RELEASE != 0);
                            push_rel   = 1'b1;
                            state_next = SCAN;
                            col_next   = col_adv;
                        end else begin
                            state_next = REL_DB;
                        end
                    end
                end
                REL_DB: begin
                    if (hit) begin
                        state_next = HELD;
                    end else begin
                        db_next = db_inc;
                        if (db_inc == DB_W'(DEBOUNCE)) begin
                            push       = (REPORT_RELEASE != 0);
                            push_rel   = 1'b1;
                            state_next = SCAN;
                            col_next   = col_adv;
                        end
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    assign full        = (count_reg == CNT_W'(DEPTH));
    assign ev_valid    = (count_reg != '0);
    assign pop         = ev_valid & ev_ready;
    assign wr_en       = push & (~full | pop);
    assign drop        = push & full & ~pop;
    assign push_data   = {push_rel, ev_code};
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    // The incoming event becomes the head when nothing else remains queued.
    assign bypass      = wr_en & ((count_reg - CNT_W'(pop)) == '0);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rows_meta_reg <= '0;
            rows_s_reg    <= '0;
            div_reg       <= '0;
            state_reg     <= SCAN;
            col_reg       <= '0;
            lrow_reg      <= '0;
            db_reg        <= '0;
            key_down_reg  <= 1'b0;
            key_code_reg  <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            data_reg      <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            rows_meta_reg <= rows;
            rows_s_reg    <= rows_meta_reg;
            div_reg       <= tick ? '0 : div_reg + 1'b1;
            state_reg     <= state_next;
            col_reg       <= col_next;
            lrow_reg      <= lrow_next;
            db_reg        <= db_next;
            key_down_reg  <= (state_next == HELD) || (state_next == REL_DB);
            if (push && !push_rel) key_code_reg <= ev_code;
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_reg + CNT_W'(wr_en) - CNT_W'(pop);
            data_reg      <= bypass ? push_data : mem[rd_ptr_next];
            if (clr_ovf)   ovf_reg <= 1'b0;
            else if (drop) ovf_reg <= 1'b1;
        end
    end

    assign ev_data  = data_reg;
    assign ev_count = count_reg;
    assign key_down = key_down_reg;
    assign key_code = key_code_reg;
    assign overflow = ovf_reg;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: a physical key matrix drives the rows from the column outputs,
// and a tick-level scanner/queue model predicts every event, flag and count.
module tb_keypad_scan_fifo;
    localparam int NR = 4, NC = 4, SD = 4, DB = 3, DP = 4, RR = 1;
    localparam int CW = $clog2(NR * NC);
    localparam int NW = $clog2(DP) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NR-1:0] rows;
    logic [NC-1:0] cols;
    logic          ev_valid, ev_ready, key_down, overflow, clr_ovf;
    logic [CW:0]   ev_data;
    logic [NW-1:0] ev_count;
    logic [CW-1:0] key_code;
    logic [NR-1:0][NC-1:0] keys;

    always #5 clk = ~clk;

    // A pressed key connects its row to its column.
    always_comb begin
        for (int r = 0; r < NR; r++) rows[r] = |(keys[r] & cols);
    end

    keypad_scan_fifo #(.NROWS(NR), .NCOLS(NC), .SCAN_DIV(SD), .DEBOUNCE(DB),
                       .DEPTH(DP), .REPORT_RELEASE(RR)) dut (
        .clk(clk), .reset_n(reset_n), .rows(rows), .cols(cols),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .ev_count(ev_count), .key_down(key_down), .key_code(key_code),
        .overflow(overflow), .clr_ovf(clr_ovf));

    typedef struct packed {
        logic       latched;
        logic       confirmed;
        logic [7:0] run;
        logic [7:0] col;
        logic [7:0] row;
    } kstate_t;

    kstate_t     ks;
    int          mdiv;
    logic [NR-1:0] rs1, rs2;
    logic [CW:0] mq[$];
    logic        movf;
    logic [CW:0] got_q[$];
    logic [CW:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // One scan tick of the single-key scanner: run counts consecutive confirming samples.
    function automatic kstate_t kstep(input kstate_t s, input logic [NR-1:0] rs, output int ev);
        kstate_t n;
        int code;
        n  = s;
        ev = -1;
        code = int'(s.row) * NC + int'(s.col);
        if (!s.latched) begin
            if (rs == '0) begin
                n.col = 8'((int'(s.col) + 1) % NC);
            end else begin
                for (int r = NR - 1; r >= 0; r--) if (rs[r]) n.row = 8'(r);
                n.latched = 1'b1; n.confirmed = 1'b0; n.run = 8'd1;
                if (DB == 1) begin
                    n.confirmed = 1'b1; n.run = 8'd0;
                    ev = int'(n.row) * NC + int'(s.col);
                end
            end
        end else if (!s.confirmed) begin
            if (rs[s.row]) begin
                n.run = s.run + 8'd1;
                if (int'(n.run) == DB) begin
                    n.confirmed = 1'b1; n.run = 8'd0; ev = code;
                end
            end else begin
                n.latched = 1'b0;
                n.col = 8'((int'(s.col) + 1) % NC);
            end
        end else begin
            if (rs[s.row]) begin
                n.run = 8'd0;
            end else begin
                n.run = s.run + 8'd1;
                if (int'(n.run) >= DB) begin
                    n.latched = 1'b0; n.confirmed = 1'b0; n.run = 8'd0;
                    n.col = 8'((int'(s.col) + 1) % NC);
                    if (RR != 0) ev = (1 << CW) | code;
                end
            end
        end
        return n;
    endfunction

    function automatic logic predict_push();
        kstate_t d;
        int ev;
        if (!reset_n || mdiv != SD - 1) return 1'b0;
        d = kstep(ks, rs2, ev);
        return ev >= 0;
    endfunction

    // Advance one clock, keeping the model in lockstep and logging popped events.
    task automatic step();
        logic rst, tick, pop, dropped;
        logic [NR-1:0] rnow;
        kstate_t nks;
        int ev;
        rst  = !reset_n;
        tick = (mdiv == SD - 1);
        pop  = !rst && mq.size() != 0 && ev_ready;
        if (!rst && ev_valid && ev_ready) got_q.push_back(ev_data);
        for (int r = 0; r < NR; r++) rnow[r] = keys[r][int'(ks.col)];
        ev  = -1;
        nks = ks;
        if (tick && !rst) nks = kstep(ks, rs2, ev);
        @(posedge clk);
        #1;
        if (rst) begin
            ks = '0; mdiv = 0; rs1 = '0; rs2 = '0; mq.delete(); movf = 1'b0;
        end else begin
            mdiv = tick ? 0 : mdiv + 1;
            rs2 = rs1; rs1 = rnow; ks = nks;
            if (pop) exp_q.push_back(mq.pop_front());
            dropped = 1'b0;
            if (ev >= 0) begin
                if (mq.size() < DP) mq.push_back(ev[CW:0]);
                else dropped = 1'b1;
            end
            if (clr_ovf) movf = 1'b0;
            else if (dropped) movf = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [NC-1:0] exp_cols;
        keys = '0; ev_ready = 1'b0; clr_ovf = 1'b0; reset_n = 1'b0;
        repeat (3) step();
        checks++; if (cols !== 4'b0001) begin errors++; $display("FAIL reset_cols got=%b exp=0001", cols); end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got=%b exp=0", ev_valid); end
        checks++; if (ev_count !== '0) begin errors++; $display("FAIL reset_ev_count got=%0d exp=0", ev_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (key_down !== 1'b0 || key_code !== '0) begin
            errors++; $display("FAIL reset_key got=%b/%0d exp=0/0", key_down, key_code); end
        reset_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            repeat (SD) step();
            exp_cols = NC'(1) << (t % NC);
            checks++; if (cols !== exp_cols) begin
                errors++; $display("FAIL rotate_%0d got=%b exp=%b", t, cols, exp_cols); end
        end
        $display("test_reset: done");
    endtask

    task automatic test_press_release();
        got_q.delete(); exp_q.delete();
        ev_ready = 1'b1;
        keys[2][1] = 1'b1;
        repeat (40) step();
        checks++; if (key_down !== 1'b1 || key_code !== 4'd9) begin
            errors++; $display("FAIL held_key got=%b/%0d exp=1/9", key_down, key_code); end
        checks++; if (cols !== 4'b0010) begin errors++; $display("FAIL held_cols got=%b exp=0010", cols); end
        keys[2][1] = 1'b0;
        repeat (40) step();
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL released_key got=%b exp=0", key_down); end
        checks++; if (got_q.size() != 2 || got_q[0] !== 5'b0_1001 || got_q[1] !== 5'b1_1001) begin
            errors++; $display("FAIL press_release_events got=%p exp='{09,19}", got_q); end
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL press_release_model got=%p exp=%p", got_q, exp_q); end
        $display("test_press_release: %0d events", got_q.size());
    endtask

    task automatic test_bounce();
        int budget;
        got_q.delete(); exp_q.delete();
        ev_ready = 1'b1;
        budget = 0;
        while (!(ks.col == 8'd0 && mdiv == 0 && !ks.latched) && budget < 64) begin
            step(); budget++;
        end
        checks++; if (budget >= 64) begin errors++; $display("FAIL bounce_sync got=timeout exp=col0"); end
        keys[1][0] = 1'b1;
        repeat (SD) step();
        keys[1][0] = 1'b0;
        repeat (40) step();
        checks++; if (ev_count !== '0 || got_q.size() != 0) begin
            errors++; $display("FAIL bounce_no_event got=%0d/%0d exp=0/0", ev_count, got_q.size()); end
        checks++; if (cols !== (NC'(1) << ks.col)) begin
            errors++; $display("FAIL bounce_scan got=%b exp=%b", cols, NC'(1) << ks.col); end
        $display("test_bounce: done");
    endtask

    task automatic test_two_rows();
        got_q.delete(); exp_q.delete();
        ev_ready = 1'b1;
        keys[0][0] = 1'b1; keys[3][0] = 1'b1;
        repeat (40) step();
        checks++; if (key_down !== 1'b1 || key_code !== 4'd0) begin
            errors++; $display("FAIL two_rows_key got=%b/%0d exp=1/0", key_down, key_code); end
        keys[0][0] = 1'b0;
        repeat (20) step();
        keys[3][0] = 1'b0;
        repeat (40) step();
        checks++; if (got_q.size() != 2 || got_q[0] !== 5'b0_0000 || got_q[1] !== 5'b1_0000) begin
            errors++; $display("FAIL two_rows_events got=%p exp='{00,10}", got_q); end
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL two_rows_model got=%p exp=%p", got_q, exp_q); end
        $display("test_two_rows: %0d events", got_q.size());
    endtask

    task automatic test_overflow();
        got_q.delete(); exp_q.delete();
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            keys[1][2] = 1'b1; repeat (40) step();
            keys[1][2] = 1'b0; repeat (40) step();
            if (i == 1) begin
                checks++; if (ev_count !== 3'd4 || overflow !== 1'b0) begin
                    errors++; $display("FAIL four_pushes got=%0d/%b exp=4/0", ev_count, overflow); end
            end
        end
        checks++; if (ev_count !== 3'd4 || overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_set got=%0d/%b exp=4/1", ev_count, overflow); end
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clr got=%b exp=0", overflow); end
        ev_ready = 1'b1;
        repeat (8) step();
        checks++; if (got_q.size() != 4 || got_q[0] !== 5'h06 || got_q[1] !== 5'h16
                      || got_q[2] !== 5'h06 || got_q[3] !== 5'h16) begin
            errors++; $display("FAIL overflow_drain got=%p exp='{06,16,06,16}", got_q); end
        checks++; if (got_q != exp_q || ev_count !== '0) begin
            errors++; $display("FAIL overflow_model got=%p/%0d exp=%p/0", got_q, ev_count, exp_q); end
        $display("test_overflow: %0d drained", got_q.size());
    endtask

    task automatic test_full_accept();
        int accepted;
        got_q.delete(); exp_q.delete();
        ev_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            keys[0][3] = 1'b1; repeat (40) step();
            keys[0][3] = 1'b0; repeat (40) step();
        end
        accepted = 0;
        keys[3][3] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c == 40) keys[3][3] = 1'b0;
            ev_ready = predict_push();
            step();
            if (ev_ready) begin
                accepted++;
                checks++; if (ev_count !== 3'd4 || overflow !== 1'b0) begin
                    errors++; $display("FAIL full_push_%0d got=%0d/%b exp=4/0", accepted, ev_count, overflow); end
            end
        end
        ev_ready = 1'b0;
        checks++; if (accepted != 2) begin errors++; $display("FAIL full_pushes got=%0d exp=2", accepted); end
        ev_ready = 1'b1;
        repeat (8) step();
        checks++; if (got_q.size() != 6 || got_q[4] !== 5'h0F || got_q[5] !== 5'h1F) begin
            errors++; $display("FAIL full_drain got=%p exp=tail 0f,1f", got_q); end
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL full_model got=%p exp=%p", got_q, exp_q); end
        $display("test_full_accept: %0d drained", got_q.size());
    endtask

    task automatic test_random();
        int r, c;
        got_q.delete(); exp_q.delete();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                r = $urandom_range(0, NR - 1); c = $urandom_range(0, NC - 1);
                keys[r][c] = ~keys[r][c];
            end
            ev_ready = ($urandom_range(0, 2) == 0);
            clr_ovf  = ($urandom_range(0, 63) == 0);
            step();
            checks++; if (cols !== (NC'(1) << ks.col)) begin
                errors++; $display("FAIL rnd_cols cyc=%0d got=%b exp=%b", n, cols, NC'(1) << ks.col); end
            checks++; if (ev_count !== NW'(mq.size()) || ev_valid !== (mq.size() != 0)) begin
                errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, ev_count, mq.size()); end
            checks++; if (overflow !== movf) begin
                errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", n, overflow, movf); end
            checks++; if (key_down !== (ks.latched & ks.confirmed)) begin
                errors++; $display("FAIL rnd_key_down cyc=%0d got=%b exp=%b", n, key_down, ks.latched & ks.confirmed); end
            if (key_down === 1'b1 && ks.latched && ks.confirmed) begin
                checks++; if (int'(key_code) != int'(ks.row) * NC + int'(ks.col)) begin
                    errors++; $display("FAIL rnd_key_code cyc=%0d got=%0d exp=%0d", n, key_code, int'(ks.row) * NC + int'(ks.col)); end
            end
            if (mq.size() != 0) begin
                checks++; if (ev_data !== mq[0]) begin
                    errors++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", n, ev_data, mq[0]); end
            end
        end
        clr_ovf = 1'b0;
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL rnd_popped got=%0d exp=%0d events", got_q.size(), exp_q.size()); end
        $display("test_random: %0d events popped", got_q.size());
    endtask

    task automatic test_mid_reset();
        keys = '0; ev_ready = 1'b0; clr_ovf = 1'b0;
        repeat (20) step();
        keys[2][2] = 1'b1; repeat (40) step();
        keys[2][2] = 1'b0; repeat (40) step();
        checks++; if (ev_count !== NW'(mq.size()) || mq.size() == 0) begin
            errors++; $display("FAIL pre_reset_count got=%0d exp=%0d", ev_count, mq.size()); end
        reset_n = 1'b0; step(); reset_n = 1'b1;
        checks++; if (ev_valid !== 1'b0 || ev_count !== '0 || cols !== 4'b0001) begin
            errors++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/0001", ev_valid, ev_count, cols); end
        $display("test_mid_reset: done");
    endtask

    initial begin
        ks = '0; mdiv = 0; rs1 = '0; rs2 = '0; movf = 1'b0;
        keys = '0; ev_ready = 1'b0; clr_ovf = 1'b0; reset_n = 1'b0;
        test_reset();
        test_press_release();
        test_bounce();
        test_two_rows();
        test_overflow();
        test_full_accept();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
